// File: rtl/lock_pkg.sv
// Shared definitions for the combination-lock sender and receiver.
package lock_pkg;

    typedef enum logic [1:0] {IDLE, PULSE, GAP, FIN} state_t;

    // Factory combination, entry 0 is pressed first.
    localparam logic [3:0] DEFAULT_CODE [4] = '{4'b1000, 4'b0001, 4'b0100, 4'b0010};
    localparam logic [2:0] STEP_IDLE = 3'd4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_code_sender_code_store.sv
// 4x4 code register file; write-through read so a same-edge write to the
// entry being fetched is seen immediately.
module code_store
    import lock_pkg::*;
(
    input  logic       clkOut,
    input  logic       rst,
    input  logic       we,
    input  logic       busy,
    input  logic [1:0] idx,
    input  logic [3:0] val,
    input  logic [1:0] rd_idx,
    output logic [3:0] rd_val
);

    logic [3:0] mem_q [4];
    logic [3:0] mem_d [4];

    // Writes are frozen while a sequence is in flight.
    always_comb begin
        mem_d = mem_q;
        if (we && !busy)
            mem_d[idx] = val;
    end

    always_ff @(posedge clkOut or posedge rst) begin
        if (rst) mem_q <= DEFAULT_CODE;
        else     mem_q <= mem_d;
    end

    assign rd_val = mem_d[rd_idx];

endmodule

// File: rtl/lock_code_sender.sv
// Plays the stored 4-step button code onto btn_out as press/release pulses.
module lock_code_sender
    import lock_pkg::*;
#(
    parameter int PULSE_CYC = 1,
    parameter int GAP_CYC   = 2
) (
    input  logic       clkOut,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       code_we,
    input  logic [1:0] code_idx,
    input  logic [3:0] code_val,
    output logic [3:0] btn_out,
    output logic       busy,
    output logic       done,
    output logic [2:0] step
);

    localparam int CW = $clog2(max2(PULSE_CYC, GAP_CYC)) + 1;

    state_t        state_q, state_d;
    logic [2:0]    step_q, step_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    btn_q, btn_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [3:0]    code_rd;

    code_store u_store (
        .clkOut (clkOut),
        .rst    (rst),
        .we     (code_we),
        .busy   (busy_q),
        .idx    (code_idx),
        .val    (code_val),
        .rd_idx (step_d[1:0]),
        .rd_val (code_rd)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = PULSE;
                step_d  = 3'd0;
                cnt_d   = '0;
            end
            PULSE: if (cnt_q == CW'(PULSE_CYC - 1)) begin
                state_d = GAP;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            GAP: if (cnt_q == CW'(GAP_CYC - 1)) begin
                cnt_d = '0;
                if (step_q == 3'd3) begin
                    state_d = FIN;
                end else begin
                    state_d = PULSE;
                    step_d  = step_q + 3'd1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            FIN: begin
                state_d = IDLE;
                step_d  = STEP_IDLE;
            end
            default: begin
                state_d = IDLE;
                step_d  = STEP_IDLE;
            end
        endcase

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            step_d  = STEP_IDLE;
            cnt_d   = '0;
        end

        // Outputs are registered from the next state so they align with it.
        btn_d  = (state_d == PULSE) ? code_rd : 4'b0000;
        busy_d = (state_d == PULSE) || (state_d == GAP);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clkOut or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= STEP_IDLE;
            cnt_q   <= '0;
            btn_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            btn_q   <= btn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign btn_out = btn_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign step    = step_q;

endmodule

// File: tb/tb_lock_code_sender.sv
// Directed + randomized bench for lock_code_sender against a trace-level model.
module tb_lock_code_sender;
    import lock_pkg::*;

    localparam int P = 1;
    localparam int G = 2;

    typedef struct packed {
        logic [3:0] btn;
        logic       busy;
        logic       done;
        logic [2:0] step;
    } obs_t;

    logic       clkOut = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       code_we = 1'b0;
    logic [1:0] code_idx = 2'd0;
    logic [3:0] code_val = 4'd0;
    logic [3:0] btn_out;
    logic       busy;
    logic       done;
    logic [2:0] step;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] model [4];

    always #5 clkOut = ~clkOut;

    lock_code_sender #(.PULSE_CYC(P), .GAP_CYC(G)) dut (
        .clkOut   (clkOut),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .code_we  (code_we),
        .code_idx (code_idx),
        .code_val (code_val),
        .btn_out  (btn_out),
        .busy     (busy),
        .done     (done),
        .step     (step)
    );

    function automatic obs_t cur();
        obs_t o;
        o = '{btn_out, busy, done, step};
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Idle-time write; the model mirrors it directly.
    task automatic wr(input logic [1:0] idx, input logic [3:0] val);
        code_we = 1'b1; code_idx = idx; code_val = val;
        @(negedge clkOut);
        code_we = 1'b0;
        model[idx] = val;
    endtask

    // Expected trace: each step is P cycles of the code then G cycles of
    // release, followed by one done cycle and a return to idle.
    task automatic run_seq(input int abort_at, input bit noise, input bit hold, input string tag);
        obs_t       exp_q[$];
        obs_t       e;
        logic [3:0] presses[$];
        logic [3:0] prev;
        bit         opened;
        bit         want_open;
        for (int s = 0; s < 4; s++) begin
            repeat (P) exp_q.push_back(obs_t'{model[s], 1'b1, 1'b0, 3'(s)});
            repeat (G) exp_q.push_back(obs_t'{4'b0000, 1'b1, 1'b0, 3'(s)});
        end
        exp_q.push_back(obs_t'{4'b0000, 1'b0, 1'b1, 3'd3});
        exp_q.push_back(obs_t'{4'b0000, 1'b0, 1'b0, STEP_IDLE});

        start = 1'b1;
        @(negedge clkOut);
        if (!hold) start = 1'b0;
        code_we = 1'b0;
        abort   = 1'b0;
        prev    = 4'b0000;
        for (int c = 0; c < exp_q.size(); c++) begin
            e = exp_q[c];
            check($sformatf("%s.c%0d", tag, c + 1), 32'(cur()), 32'(e));
            if (btn_out != 4'b0000 && prev == 4'b0000) presses.push_back(btn_out);
            prev = btn_out;
            if (abort_at == c + 1) begin
                abort = 1'b1; start = 1'b0; code_we = 1'b0;
                @(negedge clkOut);
                abort = 1'b0;
                check({tag, ".abort"}, 32'(cur()), 32'(obs_t'{4'b0000, 1'b0, 1'b0, STEP_IDLE}));
                @(negedge clkOut);
                check({tag, ".abort_nodone"}, 32'(cur()), 32'(obs_t'{4'b0000, 1'b0, 1'b0, STEP_IDLE}));
                return;
            end
            if (!hold) begin
                if (noise && e.busy) begin
                    start    = 1'($urandom);
                    code_we  = 1'($urandom);
                    code_idx = 2'($urandom);
                    code_val = 4'($urandom);
                end else begin
                    start   = 1'b0;
                    code_we = 1'b0;
                end
            end
            if (c < exp_q.size() - 1) @(negedge clkOut);
        end
        // Receiver-side view: the lock opens only on the factory press order.
        opened    = (presses.size() == 4);
        want_open = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (opened && presses[i] != DEFAULT_CODE[i]) opened = 1'b0;
            if (model[i] != DEFAULT_CODE[i]) want_open = 1'b0;
        end
        check({tag, ".lock"}, 32'(opened), 32'(want_open));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) model[i] = DEFAULT_CODE[i];
        repeat (2) @(negedge clkOut);
        check("reset", 32'(cur()), 32'(obs_t'{4'b0000, 1'b0, 1'b0, STEP_IDLE}));
        rst = 1'b0;
        @(negedge clkOut);

        run_seq(-1, 1'b0, 1'b0, "default");

        wr(2'd2, 4'b1000);
        run_seq(-1, 1'b0, 1'b0, "wr2");
        run_seq(-1, 1'b1, 1'b0, "noise");

        run_seq(8, 1'b1, 1'b0, "abort");
        run_seq(-1, 1'b0, 1'b0, "replay");

        abort = 1'b1;
        run_seq(-1, 1'b0, 1'b0, "start_abort");

        // Same-edge write of entry 0 and start: the send uses the new value.
        code_we = 1'b1; code_idx = 2'd0; code_val = 4'b0110;
        model[0] = 4'b0110;
        run_seq(-1, 1'b0, 1'b0, "wr_start");

        wr(2'd3, 4'b0001);
        run_seq(-1, 1'b0, 1'b0, "e3_0001");

        for (int i = 0; i < 4; i++) wr(2'(i), DEFAULT_CODE[i]);
        run_seq(-1, 1'b0, 1'b1, "hold");
        @(negedge clkOut);
        check("hold.restart", 32'(cur()), 32'(obs_t'{model[0], 1'b1, 1'b0, 3'd0}));
        start = 1'b0; abort = 1'b1;
        @(negedge clkOut);
        abort = 1'b0;
        check("hold.abort", 32'(cur()), 32'(obs_t'{4'b0000, 1'b0, 1'b0, STEP_IDLE}));

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) wr(2'(i), 4'($urandom_range(0, 15)));
            run_seq(-1, 1'b1, 1'b0, $sformatf("rnd%0d", r));
        end

        // Asynchronous reset in the middle of step 1's pulse.
        wr(2'd1, 4'b1111);
        start = 1'b1;
        @(negedge clkOut);
        start = 1'b0;
        repeat (3) @(negedge clkOut);
        check("pre_rst", 32'(cur()), 32'(obs_t'{4'b1111, 1'b1, 1'b0, 3'd1}));
        #2 rst = 1'b1;
        #1 check("mid_rst", 32'(cur()), 32'(obs_t'{4'b0000, 1'b0, 1'b0, STEP_IDLE}));
        @(negedge clkOut);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = DEFAULT_CODE[i];
        @(negedge clkOut);
        run_seq(-1, 1'b0, 1'b0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
